// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the chunk-serial multiword adder.
// Chunk width and FSM state encoding live here so every file agrees on them.
package multiword_add_seq_pkg;

    localparam int CHUNK_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multiword_add_seq_adder.sv
// One 16-bit chunk adder with carry in and carry out; purely combinational.
module sixteen_adder
    import multiword_add_seq_pkg::*;
(
    input  logic [CHUNK_W-1:0] i_a,
    input  logic [CHUNK_W-1:0] i_b,
    input  logic               i_cin,
    output logic [CHUNK_W-1:0] o_sum,
    output logic               o_cout
);

    logic [CHUNK_W:0] w_full;

    assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK_W{1'b0}}, i_cin};
    assign o_sum  = w_full[CHUNK_W-1:0];
    assign o_cout = w_full[CHUNK_W];

endmodule

// File: rtl/multiword_add_seq.sv
// Chunk-serial adder: one 16-bit chunk per cycle through a single shared adder,
// result held in DONE until the consumer takes it.
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHUNK_W*WORDS-1:0] a,
    input  logic [CHUNK_W*WORDS-1:0] b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CHUNK_W*WORDS-1:0] sum,
    output logic                     cout,
    output logic                     ovf,
    output logic                     busy
);

    localparam int SUM_W = CHUNK_W * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t               r_state;
    state_t               w_next;
    logic [SUM_W-1:0]     r_a;
    logic [SUM_W-1:0]     r_b;
    logic [SUM_W-1:0]     r_sum;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_carry;
    logic                 r_cout;
    logic                 r_ovf;

    logic [CHUNK_W-1:0]   w_a_k;
    logic [CHUNK_W-1:0]   w_b_k;
    logic [CHUNK_W-1:0]   w_s_k;
    logic                 w_c_k;
    logic                 w_accept;
    logic                 w_last;

    assign w_a_k    = r_a[r_idx*CHUNK_W +: CHUNK_W];
    assign w_b_k    = r_b[r_idx*CHUNK_W +: CHUNK_W];
    assign w_accept = (r_state == IDLE) && in_valid;
    assign w_last   = (r_idx == LAST_IDX);

    sixteen_adder u_adder (
        .i_a    (w_a_k),
        .i_b    (w_b_k),
        .i_cin  (r_carry),
        .o_sum  (w_s_k),
        .o_cout (w_c_k)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (w_last) w_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Operands are snapshotted at accept so input changes during RUN are invisible.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_sum   <= '0;
        end else if (r_state == RUN) begin
            r_sum[r_idx*CHUNK_W +: CHUNK_W] <= w_s_k;
            r_carry <= w_c_k;
            r_idx   <= r_idx + IDX_W'(1);
            if (w_last) begin
                r_cout <= w_c_k;
                r_ovf  <= (r_a[SUM_W-1] == r_b[SUM_W-1]) &&
                          (w_s_k[CHUNK_W-1] != r_a[SUM_W-1]);
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Scoreboard bench for multiword_add_seq with WORDS=4 and hand-computed vectors.
module tb_multiword_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 16 * WORDS;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    multiword_add_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   acc_neg = -100;
    logic acc_pend = 1'b0;
    logic prev_ov = 1'b0;
    bit   cont_mode = 1'b0;
    int   cont_n = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: accept tracking and result checking on the first DONE cycle.
    always @(negedge clk) begin
        cyc++;
        if (acc_pend) begin
            if (cont_mode) begin
                if (cont_n > 0) check("accept_period", W'(cyc - acc_neg), W'(6));
                cont_n++;
            end
            acc_neg = cyc;
        end
        acc_pend = (in_ready === 1'b1) && in_valid && !rst;
        if (out_valid === 1'b1 && !prev_ov) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got sum %h with no pending operation", sum);
            end else begin
                mon_e = exp_q.pop_front();
                check("sum", sum, mon_e.s);
                check("cout", W'(cout), W'(mon_e.c));
                check("ovf", W'(ovf), W'(mon_e.o));
                check("latency", W'(cyc - acc_neg), W'(WORDS));
            end
        end
        prev_ov = (out_valid === 1'b1);
    end

    // Present operands until accepted; called just after a rising edge.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                         input logic [W-1:0] es, input logic ec, input logic eo, input bit keep);
        bit got = 1'b0;
        a = ta;
        b = tb_v;
        cin = tc;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                exp_q.push_back('{es, ec, eo});
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got in_ready %b, expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got %0d pending results, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [W-1:0] V5A = 64'h1234_5678_9ABC_DEF0;
    localparam logic [W-1:0] V5B = 64'h1111_1111_1111_1111;
    localparam logic [W-1:0] V5S = 64'h2345_6789_ABCD_F001;
    localparam logic [W-1:0] V6A = 64'hFFFF_0000_FFFF_0000;
    localparam logic [W-1:0] V6B = 64'h0001_0000_0001_0000;
    localparam logic [W-1:0] V6S = 64'h0000_0001_0000_0001;

    initial begin
        bit seen_ov = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_sum", sum, '0);
        check("rst_cout", W'(cout), W'(0));
        check("rst_ovf", W'(ovf), W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        issue(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        wait_done();
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        wait_done();
        issue(64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b0);
        wait_done();

        // Consumer stalls in DONE while new operands are offered.
        out_ready = 1'b0;
        issue(V5A, V5B, 1'b0, V5S, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen_ov = 1'b1;
                break;
            end
        end
        check("stall_reached_done", W'(seen_ov), W'(1));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            cin = 1'(i);
            @(negedge clk);
            check("stall_sum", sum, V5S);
            check("stall_cout", W'(cout), W'(0));
            check("stall_ovf", W'(ovf), W'(0));
            check("stall_in_ready", W'(in_ready), W'(0));
            check("stall_out_valid", W'(out_valid), W'(1));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_done();

        issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1, 1'b0);
        wait_done();

        // Reset during the second RUN cycle discards the operation.
        issue(V6A, V6B, 1'b1, V6S, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("run_busy", W'(busy), W'(1));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("abort_in_ready", W'(in_ready), W'(1));
        check("abort_out_valid", W'(out_valid), W'(0));
        check("abort_busy", W'(busy), W'(0));
        check("abort_sum", sum, '0);
        check("abort_cout", W'(cout), W'(0));
        check("abort_ovf", W'(ovf), W'(0));
        @(posedge clk);
        #1;
        issue(V6A, V6B, 1'b1, V6S, 1'b1, 1'b0, 1'b0);
        wait_done();

        // Back-to-back traffic with both handshakes held high.
        out_ready = 1'b1;
        cont_mode = 1'b1;
        issue(V5A, V5B, 1'b0, V5S, 1'b0, 1'b0, 1'b1);
        issue(V6A, V6B, 1'b1, V6S, 1'b1, 1'b0, 1'b1);
        issue(64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0, 1'b1);
        issue(64'h1, 64'h1, 1'b0, 64'h2, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
        wait_done();
        cont_mode = 1'b0;
        check("cont_accepts", W'(cont_n), W'(4));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multiword_add_seq.md
MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 SHALL have parameter WORDS, default 4, giving the number of 16-bit chunks per operand; legal range is 1..8.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on the clk rising edge.
REQ-004 SHALL have port in_valid  input  1  operand set is valid.
REQ-005 SHALL have port in_ready  output  1  block can accept operands.
REQ-006 SHALL have ports a, b  input  16*WORDS  unsigned/two's-complement operands.
REQ-007 SHALL have port cin  input  1  carry-in to chunk 0.
REQ-008 SHALL have port out_valid  output  1  result is valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port sum  output  16*WORDS  registered a+b+cin modulo 2^(16*WORDS).
REQ-011 SHALL have port cout  output  1  carry out of the top chunk.
REQ-012 SHALL have port ovf  output  1  signed overflow: a and b have equal MSBs and sum MSB differs.
REQ-013 SHALL have port busy  output  1  high in RUN.

Function
REQ-014 SHALL implement FSM states IDLE, RUN, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE, busy=1 only in RUN, and out_valid=1 only in DONE.
REQ-016 SHALL accept operands on the edge where state==IDLE and in_valid=1, capturing a, b and cin into internal registers, clearing the chunk index, and entering RUN.
REQ-017 SHALL, in RUN, process chunk k (bits 16k+15:16k) in each cycle: feed a_k, b_k and the carry register into one 16-bit adder, write the adder sum into sum bits [16k+15:16k], and load the carry register with the adder carry-out.
REQ-018 SHALL initialise the carry register to the captured cin for chunk 0.
REQ-019 SHALL, after chunk WORDS-1, register cout = final carry and ovf = signed overflow, and enter DONE; out_valid SHALL first be high exactly WORDS cycles after the accept edge.
REQ-020 SHALL hold sum, cout and ovf stable throughout DONE until the handshake completes.
REQ-021 SHALL, in DONE with out_ready=1, return to IDLE on that edge; no accept occurs in the same cycle, so the minimum period between accepts is WORDS+2 cycles.
REQ-022 SHALL ignore in_valid while in RUN or DONE; a, b and cin changing in RUN SHALL not affect the result.
REQ-023 SHALL clear sum to 0 at accept; no partial sum is observable as valid.
REQ-024 SHALL wrap the result modulo 2^(16*WORDS); the carry beyond the top chunk appears only on cout.
REQ-025 SHALL, for WORDS=1, go IDLE->RUN->DONE with one RUN cycle.

Reset
REQ-026 SHALL, when rst=1, on the next edge set state=IDLE, chunk index=0, carry register=0, sum=0, cout=0 and ovf=0, giving in_ready=1, out_valid=0 and busy=0.
REQ-027 SHALL give reset priority over every other event, including mid-RUN and a DONE handshake; the in-flight operation is discarded.

Structure
REQ-028 SHALL place CHUNK_W=16 and the state enumeration (IDLE, RUN, DONE) in a shared package.
REQ-029 SHALL instantiate exactly one sixteen_adder as the chunk datapath sub-module; all sequencing, carry and result registers reside in multiword_add_seq.
REQ-030 SHALL size the chunk index as the ceiling of log2(WORDS), with a minimum of 1 bit.

Verification (WORDS=4)
REQ-031 SHALL test a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0, cout=1, ovf=0, with out_valid high 4 cycles after accept.
REQ-032 SHALL test a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
REQ-033 SHALL test a=0x0000_0000_0000_FFFF, b=0, cin=1 -> sum=0x0000_0000_0001_0000, confirming the carry crosses the chunk boundary.
REQ-034 SHALL test out_ready held low 10 cycles in DONE with in_valid=1 and new operands applied -> sum/cout/ovf unchanged, in_ready=0, and no new accept.
REQ-035 SHALL test rst pulsed in the 2nd RUN cycle -> next cycle state IDLE, sum=0, cout=0, ovf=0, in_ready=1, out_valid=0.
REQ-036 SHALL test in_valid and out_ready held high continuously -> accepts occur every 6 cycles with correct results for each operand set.
